// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for the downstream
// one-hot channel selector; grants are locked per burst and handed off back-to-back.
//
//   state    | meaning
//   ST_IDLE  | no channel granted, o_sel = 0
//   ST_GRANT | one channel (r_grant_idx) owns o_sel until last beat or abort
module rr_onehot_arbiter #(
  parameter int INPUT_CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INPUT_CHANNELS-1:0] i_req,
  input  logic [INPUT_CHANNELS-1:0] i_last,
  input  logic                      i_ready,
  output logic [INPUT_CHANNELS-1:0] o_sel,
  output logic                      o_valid,
  output logic [INPUT_CHANNELS-1:0] o_ack,
  output logic [((INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1)-1:0] o_grant_idx
);

  localparam int N  = INPUT_CHANNELS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0]   LP_N   = (IW+1)'(N);
  localparam logic [IW-1:0] LP_NM1 = IW'(N - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_sel, w_sel_nxt;
  logic [IW-1:0] r_grant_idx, w_idx_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;

  logic          w_req_g, w_last_g, w_valid, w_xfer;
  logic [IW-1:0] w_rel_ptr, w_arb_ptr;
  logic [N-1:0]  w_rot;
  logic          w_found;
  logic [IW-1:0] w_off, w_win_idx;
  logic [IW:0]   w_sum;
  logic [N-1:0]  w_win_oh;

  assign w_req_g  = |(i_req & r_sel);
  assign w_last_g = |(i_last & r_sel);
  assign w_valid  = (r_state == ST_GRANT) && w_req_g;
  assign w_xfer   = w_valid && i_ready;

  // Pointer after releasing g: the released channel drops to lowest priority.
  assign w_rel_ptr = (r_grant_idx == LP_NM1) ? '0 : r_grant_idx + 1'b1;
  assign w_arb_ptr = (r_state == ST_GRANT) ? w_rel_ptr : r_ptr;

  // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
  assign w_rot = N'({i_req, i_req} >> w_arb_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k[IW-1:0];
      end
    end
  end

  assign w_sum     = {1'b0, w_arb_ptr} + {1'b0, w_off};
  assign w_win_idx = (w_sum >= LP_N) ? IW'(w_sum - LP_N) : w_sum[IW-1:0];
  assign w_win_oh  = N'(1) << w_win_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_grant_idx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_win_oh;
          w_idx_nxt   = w_win_idx;
        end
      end
      ST_GRANT: begin
        if (!w_req_g) begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = '0;
          w_idx_nxt   = '0;
          w_ptr_nxt   = w_rel_ptr;
        end else if (w_xfer && w_last_g) begin
          w_ptr_nxt = w_rel_ptr;
          if (w_found) begin
            w_sel_nxt = w_win_oh;
            w_idx_nxt = w_win_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = '0;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_grant_idx <= w_idx_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign o_sel       = r_sel;
  assign o_grant_idx = r_grant_idx;
  assign o_valid     = w_valid;
  assign o_ack       = r_sel & {N{w_xfer}};

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios on a 2-channel instance and a
// reference-model-checked random run on a 4-channel instance.
module tb_rr_onehot_arbiter;

  logic clk;
  logic rst2_n, rst4_n;

  logic [1:0] req2, last2, sel2, ack2;
  logic       rdy2, val2;
  logic [0:0] gi2;

  logic [3:0] req4, last4, sel4, ack4;
  logic       rdy4, val4;
  logic [1:0] gi4;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state for the 4-channel instance
  bit m_busy;
  int m_g;
  int m_ptr;

  rr_onehot_arbiter #(.INPUT_CHANNELS(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .i_req(req2), .i_last(last2), .i_ready(rdy2),
    .o_sel(sel2), .o_valid(val2), .o_ack(ack2), .o_grant_idx(gi2)
  );

  rr_onehot_arbiter #(.INPUT_CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .i_req(req4), .i_last(last4), .i_ready(rdy4),
    .o_sel(sel4), .o_valid(val4), .o_ack(ack4), .o_grant_idx(gi4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step2(input logic [1:0] r, input logic [1:0] l, input logic rd);
    @(negedge clk);
    req2 = r; last2 = l; rdy2 = rd;
    #1;
  endtask

  function automatic int pick4(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Drive one cycle on the 4-channel instance, check against the model, then advance the model.
  task automatic step4(input logic [3:0] r, input logic [3:0] l, input logic rd, input int exp_sel_c);
    logic [3:0] e_sel, e_ack;
    logic       e_val;
    int         w;
    @(negedge clk);
    req4 = r; last4 = l; rdy4 = rd;
    #1;
    e_sel = m_busy ? (4'b0001 << m_g) : 4'b0000;
    e_val = m_busy && r[m_g];
    e_ack = (e_val && rd) ? e_sel : 4'b0000;
    chk("n4_sel", 32'(sel4), 32'(e_sel));
    chk("n4_valid", 32'(val4), 32'(e_val));
    chk("n4_ack", 32'(ack4), 32'(e_ack));
    chk("n4_grant_idx", 32'(gi4), m_busy ? 32'(m_g) : 32'd0);
    if (exp_sel_c >= 0) chk("n4_plan_sel", 32'(sel4), 32'(exp_sel_c));
    @(posedge clk);
    if (!m_busy) begin
      w = pick4(r, m_ptr);
      if (w >= 0) begin m_busy = 1'b1; m_g = w; end
    end else if (!r[m_g]) begin
      m_busy = 1'b0;
      m_ptr  = (m_g + 1) % 4;
    end else if (rd && l[m_g]) begin
      m_ptr = (m_g + 1) % 4;
      w = pick4(r, m_ptr);
      if (w >= 0) m_g = w;
      else m_busy = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] rr;
    rst2_n = 1'b1; rst4_n = 1'b1;
    req2 = '0; last2 = '0; rdy2 = 1'b0;
    req4 = '0; last4 = '0; rdy4 = 1'b0;
    m_busy = 1'b0; m_g = 0; m_ptr = 0;
    #1;
    rst2_n = 1'b0; rst4_n = 1'b0;
    #1;
    chk("rst_sel2", 32'(sel2), 32'd0);
    chk("rst_valid2", 32'(val2), 32'd0);
    chk("rst_ack2", 32'(ack2), 32'd0);
    chk("rst_gi2", 32'(gi2), 32'd0);
    chk("rst_sel4", 32'(sel4), 32'd0);
    @(negedge clk);
    rst2_n = 1'b1; rst4_n = 1'b1;

    // alternating back-to-back single-beat bursts
    step2(2'b11, 2'b11, 1'b1);
    chk("rr_idle_valid", 32'(val2), 32'd0);
    chk("rr_idle_sel", 32'(sel2), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step2(2'b11, 2'b11, 1'b1);
      chk("rr_sel", 32'(sel2), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_ack", 32'(ack2), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_valid", 32'(val2), 32'd1);
    end
    // channel 0 now granted; dropping req aborts it
    step2(2'b00, 2'b00, 1'b1);
    chk("drop_valid", 32'(val2), 32'd0);
    chk("drop_ack", 32'(ack2), 32'd0);

    // burst lock on channel 0 with channel 1 pending
    step2(2'b01, 2'b00, 1'b0);
    chk("lock_idle_sel", 32'(sel2), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step2(2'b11, 2'b00, 1'b1);
      chk("lock_sel", 32'(sel2), 32'd1);
      chk("lock_ack", 32'(ack2), 32'd1);
    end
    step2(2'b11, 2'b01, 1'b1);
    chk("lock_last_ack", 32'(ack2), 32'd1);
    step2(2'b11, 2'b10, 1'b0);
    chk("lock_handoff_sel", 32'(sel2), 32'd2);
    chk("lock_handoff_gi", 32'(gi2), 32'd1);

    // backpressure on channel 1
    for (int k = 0; k < 4; k++) begin
      step2(2'b11, 2'b10, 1'b0);
      chk("bp_sel", 32'(sel2), 32'd2);
      chk("bp_valid", 32'(val2), 32'd1);
      chk("bp_ack", 32'(ack2), 32'd0);
    end
    step2(2'b11, 2'b00, 1'b1);
    chk("bp_release_ack", 32'(ack2), 32'd2);
    step2(2'b11, 2'b00, 1'b0);
    chk("bp_single_pulse", 32'(ack2), 32'd0);
    chk("bp_sel_held", 32'(sel2), 32'd2);

    // abort of channel 1 with channel 0 pending
    step2(2'b01, 2'b00, 1'b1);
    chk("abort_valid", 32'(val2), 32'd0);
    chk("abort_ack", 32'(ack2), 32'd0);
    chk("abort_sel", 32'(sel2), 32'd2);
    step2(2'b01, 2'b00, 1'b1);
    chk("abort_idle_sel", 32'(sel2), 32'd0);
    chk("abort_idle_gi", 32'(gi2), 32'd0);
    step2(2'b01, 2'b00, 1'b1);
    chk("abort_regrant_sel", 32'(sel2), 32'd1);
    chk("abort_regrant_ack", 32'(ack2), 32'd1);

    // asynchronous reset mid-burst
    #2;
    rst2_n = 1'b0;
    #1;
    chk("areset_sel", 32'(sel2), 32'd0);
    chk("areset_valid", 32'(val2), 32'd0);
    chk("areset_ack", 32'(ack2), 32'd0);
    chk("areset_gi", 32'(gi2), 32'd0);
    @(negedge clk);
    rst2_n = 1'b1; req2 = 2'b10; last2 = 2'b00; rdy2 = 1'b0;
    @(negedge clk);
    #1;
    chk("areset_regrant_sel", 32'(sel2), 32'd2);
    chk("areset_regrant_gi", 32'(gi2), 32'd1);
    chk("areset_regrant_valid", 32'(val2), 32'd1);

    // 4-channel pointer wrap, then random traffic against the model
    step4(4'b1010, 4'b0000, 1'b0, 0);
    step4(4'b1010, 4'b0010, 1'b1, 4'b0010);
    step4(4'b1010, 4'b1000, 1'b1, 4'b1000);
    step4(4'b1010, 4'b0000, 1'b0, 4'b0010);
    rr = 4'b1010;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      step4(rr, 4'($urandom), ($urandom_range(0, 3) != 0), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
